// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: branch resolution, data-memory access FSM, MEM/WB register
//
// Purpose: consumes the EX/MEM register, resolves branches/jumps, runs loads and
// stores through a req/ack data-memory port (IDLE -> ACCESS -> DONE), aligns and
// extends load data, and drives the MEM/WB register.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_mem_*                   EX/MEM register outputs (data, control, ALU flags, targets)
//   dmem_req/we/addr/be/wdata  registered data-memory request, held stable through ACCESS
//   dmem_ack, dmem_rdata       access complete, read word valid with ack
//   pc_src, pc_target          fetch redirect
//   stall_mem                  freeze IF/ID/EX and the EX/MEM register
//   mem_wb_data/rd/ctrl_reg_write  MEM/WB register
//   mem_misalign               (MEM_MISALIGN_TRAP_EN only) one-cycle misaligned-access pulse
//
// Build option: MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and adds mem_misalign.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ex_mem_alu_out,
  input  logic [31:0]       ex_mem_reg_b_data,
  input  logic [4:0]        ex_mem_rd,
  input  logic              ex_mem_ctrl_reg_write,
  input  logic              ex_mem_ctrl_mem_to_reg,
  input  logic              ex_mem_ctrl_mem_write,
  input  logic [2:0]        ex_mem_ctrl_load_type,
  input  logic [1:0]        ex_mem_ctrl_store_type,
  input  logic              ex_mem_ctrl_branch,
  input  logic              ex_mem_ctrl_jump,
  input  logic              ex_mem_ctrl_jump_reg,
  input  logic [2:0]        ex_mem_ctrl_branch_type,
  input  logic              ex_mem_alu_beq_sig,
  input  logic              ex_mem_alu_bne_sig,
  input  logic              ex_mem_alu_bgez_sig,
  input  logic              ex_mem_alu_bgtz_sig,
  input  logic              ex_mem_alu_blez_sig,
  input  logic              ex_mem_alu_bltz_sig,
  input  logic [31:0]       ex_mem_pc_branch,
  input  logic [31:0]       ex_mem_pc_jump,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic              stall_mem,
  output logic [31:0]       mem_wb_data,
  output logic [4:0]        mem_wb_rd,
  output logic              mem_wb_ctrl_reg_write
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              mem_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d, ldbuf_q, ldbuf_d;
  logic                wb_rw_q, wb_rw_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [31:0]         wb_data_q, wb_data_d;

  logic [1:0]  off;
  logic        mem_op_raw, mem_op, trap, cond, taken;
  logic [31:0] addr_word, st_wdata, ld_ext;
  logic [3:0]  st_be;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  assign off        = ex_mem_alu_out[1:0];
  assign mem_op_raw = ex_mem_ctrl_mem_to_reg | ex_mem_ctrl_mem_write;
  assign addr_word  = {ex_mem_alu_out[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign, misalign_q;

  // Stores take precedence in deciding the access width; unknown types act as words.
  always_comb begin
    misalign = 1'b0;
    if (ex_mem_ctrl_mem_write) begin
      case (ex_mem_ctrl_store_type)
        2'd1:    misalign = off[0];
        2'd2:    misalign = 1'b0;
        default: misalign = |off;
      endcase
    end else if (ex_mem_ctrl_mem_to_reg) begin
      case (ex_mem_ctrl_load_type)
        3'd1, 3'd2: misalign = off[0];
        3'd3, 3'd4: misalign = 1'b0;
        default:    misalign = |off;
      endcase
    end
  end

  assign trap   = (state_q == IDLE) & misalign;
  assign mem_op = mem_op_raw & ~misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= trap;
  end
  assign mem_misalign = misalign_q;
`else
  assign trap   = 1'b0;
  assign mem_op = mem_op_raw;
`endif

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_mem_reg_b_data;
    case (ex_mem_ctrl_store_type)
      2'd1: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_mem_reg_b_data[15:0]}};
      end
      2'd2: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{ex_mem_reg_b_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Extension reads the captured word; the offset comes from the still-held EX/MEM address.
  always_comb begin
    ld_half = off[1] ? ldbuf_q[31:16] : ldbuf_q[15:0];
    case (off)
      2'd0:    ld_byte = ldbuf_q[7:0];
      2'd1:    ld_byte = ldbuf_q[15:8];
      2'd2:    ld_byte = ldbuf_q[23:16];
      default: ld_byte = ldbuf_q[31:24];
    endcase
    case (ex_mem_ctrl_load_type)
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_ext = {16'h0000, ld_half};
      3'd3:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'h000000, ld_byte};
      default: ld_ext = ldbuf_q;
    endcase
  end

  always_comb begin
    case (ex_mem_ctrl_branch_type)
      3'd0:    cond = ex_mem_alu_beq_sig;
      3'd1:    cond = ex_mem_alu_bne_sig;
      3'd2:    cond = ex_mem_alu_bgez_sig;
      3'd3:    cond = ex_mem_alu_bgtz_sig;
      3'd4:    cond = ex_mem_alu_blez_sig;
      3'd5:    cond = ex_mem_alu_bltz_sig;
      default: cond = 1'b0;
    endcase
  end

  assign taken     = ex_mem_ctrl_branch & cond;
  assign stall_mem = ((state_q == IDLE) & mem_op) | (state_q == ACCESS);
  assign pc_src    = (taken | ex_mem_ctrl_jump | ex_mem_ctrl_jump_reg) & ~stall_mem;
  assign pc_target = (ex_mem_ctrl_jump | ex_mem_ctrl_jump_reg) ? ex_mem_pc_jump : ex_mem_pc_branch;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ldbuf_d = ldbuf_q;
    case (state_q)
      IDLE: if (mem_op) begin
        state_d = ACCESS;
        req_d   = 1'b1;
        we_d    = ex_mem_ctrl_mem_write;
        addr_d  = addr_word[ADDR_W-1:0];
        be_d    = ex_mem_ctrl_mem_write ? st_be : 4'b1111;
        wdata_d = st_wdata;
      end
      ACCESS: if (dmem_ack) begin
        ldbuf_d = dmem_rdata;
        req_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Retire only when not stalled: IDLE for non-memory ops, DONE for memory ops.
  always_comb begin
    wb_rw_d   = 1'b0;
    wb_rd_d   = 5'd0;
    wb_data_d = 32'd0;
    if (!stall_mem && !trap) begin
      wb_rw_d   = ex_mem_ctrl_reg_write;
      wb_rd_d   = ex_mem_rd;
      wb_data_d = ex_mem_ctrl_mem_to_reg ? ld_ext : ex_mem_alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      ldbuf_q   <= 32'd0;
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ldbuf_q   <= ldbuf_d;
      wb_rw_q   <= wb_rw_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign dmem_req              = req_q;
  assign dmem_we               = we_q;
  assign dmem_addr             = addr_q;
  assign dmem_be               = be_q;
  assign dmem_wdata            = wdata_q;
  assign mem_wb_data           = wb_data_q;
  assign mem_wb_rd             = wb_rd_q;
  assign mem_wb_ctrl_reg_write = wb_rw_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, corner sequences, random vs model
module tb_mem_stage;

  typedef struct {
    logic [31:0] alu, b, pcb, pcj;
    logic [4:0]  rd;
    logic        rw, m2r, mw, br, j, jr;
    logic [2:0]  lt, bt;
    logic [1:0]  st;
    logic [5:0]  flags;  // {bltz,blez,bgtz,bgez,bne,beq}
  } instr_t;

  typedef struct {
    instr_t      in;
    int          ack_cyc;  // ACCESS cycle (1-based) that carries the ack
    logic [31:0] rdata;
    int          exp_stalls;
    logic [31:0] exp_addr, exp_wdata, exp_data, exp_target;
    logic [3:0]  exp_be;
    logic        exp_we, exp_rw, exp_pcsrc;
  } vec_t;

  logic        clk, rst_n;
  logic [31:0] ex_mem_alu_out, ex_mem_reg_b_data, ex_mem_pc_branch, ex_mem_pc_jump;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write;
  logic [2:0]  ex_mem_ctrl_load_type, ex_mem_ctrl_branch_type;
  logic [1:0]  ex_mem_ctrl_store_type;
  logic        ex_mem_ctrl_branch, ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg;
  logic        beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s;
  logic        dmem_req, dmem_we, dmem_ack, pc_src, stall_mem, mem_wb_ctrl_reg_write;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, pc_target, mem_wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  mem_wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  int checks = 0;
  int failures = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_reg_b_data(ex_mem_reg_b_data), .ex_mem_rd(ex_mem_rd),
    .ex_mem_ctrl_reg_write(ex_mem_ctrl_reg_write), .ex_mem_ctrl_mem_to_reg(ex_mem_ctrl_mem_to_reg),
    .ex_mem_ctrl_mem_write(ex_mem_ctrl_mem_write), .ex_mem_ctrl_load_type(ex_mem_ctrl_load_type),
    .ex_mem_ctrl_store_type(ex_mem_ctrl_store_type), .ex_mem_ctrl_branch(ex_mem_ctrl_branch),
    .ex_mem_ctrl_jump(ex_mem_ctrl_jump), .ex_mem_ctrl_jump_reg(ex_mem_ctrl_jump_reg),
    .ex_mem_ctrl_branch_type(ex_mem_ctrl_branch_type),
    .ex_mem_alu_beq_sig(beq_s), .ex_mem_alu_bne_sig(bne_s), .ex_mem_alu_bgez_sig(bgez_s),
    .ex_mem_alu_bgtz_sig(bgtz_s), .ex_mem_alu_blez_sig(blez_s), .ex_mem_alu_bltz_sig(bltz_s),
    .ex_mem_pc_branch(ex_mem_pc_branch), .ex_mem_pc_jump(ex_mem_pc_jump),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_src(pc_src), .pc_target(pc_target), .stall_mem(stall_mem),
    .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .mem_wb_ctrl_reg_write(mem_wb_ctrl_reg_write)
`ifdef MEM_MISALIGN_TRAP_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t i);
    ex_mem_alu_out = i.alu;  ex_mem_reg_b_data = i.b;  ex_mem_rd = i.rd;
    ex_mem_ctrl_reg_write = i.rw;  ex_mem_ctrl_mem_to_reg = i.m2r;  ex_mem_ctrl_mem_write = i.mw;
    ex_mem_ctrl_load_type = i.lt;  ex_mem_ctrl_store_type = i.st;
    ex_mem_ctrl_branch = i.br;  ex_mem_ctrl_jump = i.j;  ex_mem_ctrl_jump_reg = i.jr;
    ex_mem_ctrl_branch_type = i.bt;
    {bltz_s, blez_s, bgtz_s, bgez_s, bne_s, beq_s} = i.flags;
    ex_mem_pc_branch = i.pcb;  ex_mem_pc_jump = i.pcj;
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic vec_t mkv(input instr_t i, input int ack, input logic [31:0] rdw, input int stalls,
                               input logic [31:0] a, input logic [3:0] be, input logic we,
                               input logic [31:0] wd, input logic rw, input logic [31:0] d,
                               input logic ps, input logic [31:0] tg);
    vec_t v;
    v.in = i; v.ack_cyc = ack; v.rdata = rdw; v.exp_stalls = stalls; v.exp_addr = a;
    v.exp_be = be; v.exp_we = we; v.exp_wdata = wd; v.exp_rw = rw; v.exp_data = d;
    v.exp_pcsrc = ps; v.exp_target = tg;
    return v;
  endfunction

  // Reference model: byte/half extraction by shifting the word, replication by multiplication.
  function automatic vec_t model(input vec_t v);
    int unsigned off;
    logic [31:0] bv, hv;
    logic        is_mem, tk;
    off    = 32'(v.in.alu & 32'h3);
    is_mem = v.in.m2r | v.in.mw;
    bv = (v.rdata >> (8 * off)) & 32'hFF;
    hv = (v.rdata >> (16 * (off / 2))) & 32'hFFFF;
    v.exp_stalls = is_mem ? 1 + v.ack_cyc : 0;
    v.exp_addr   = v.in.alu & ~32'h3;
    v.exp_we     = v.in.mw;
    v.exp_be     = 4'hF;
    v.exp_wdata  = v.in.b;
    if (v.in.mw && v.in.st == 2'd1) begin
      v.exp_be = (off >= 2) ? 4'hC : 4'h3;  v.exp_wdata = (v.in.b & 32'hFFFF) * 32'h0001_0001;
    end else if (v.in.mw && v.in.st == 2'd2) begin
      v.exp_be = 4'(1 << off);  v.exp_wdata = (v.in.b & 32'hFF) * 32'h0101_0101;
    end
    v.exp_rw   = v.in.rw;
    v.exp_data = v.in.alu;
    if (v.in.m2r) begin
      case (v.in.lt)
        3'd1:    v.exp_data = (hv >= 32'h8000) ? hv - 32'h1_0000 : hv;
        3'd2:    v.exp_data = hv;
        3'd3:    v.exp_data = (bv >= 32'h80) ? bv - 32'h100 : bv;
        3'd4:    v.exp_data = bv;
        default: v.exp_data = v.rdata;
      endcase
    end
    tk = v.in.br && (v.in.bt < 3'd6) && v.in.flags[v.in.bt];
    v.exp_pcsrc  = tk | v.in.j | v.in.jr;
    v.exp_target = (v.in.j | v.in.jr) ? v.in.pcj : v.in.pcb;
    return v;
  endfunction

  // Entered and left at posedge+1; one instruction from first presentation to retirement.
  task automatic exec(input vec_t v);
    int  stalls = 0;
    int  acc = 0;
    bit  retired = 0;
    drive(v.in);
    for (int c = 0; c < 20 && !retired; c++) begin
      @(negedge clk);
      if (stall_mem) begin
        stalls++;
        chk("pc_src_in_stall", 32'(pc_src), 32'd0);
        if (dmem_req) begin
          acc++;
          chk("dmem_addr", dmem_addr, v.exp_addr);
          chk("dmem_be", 32'(dmem_be), 32'(v.exp_be));
          chk("dmem_we", 32'(dmem_we), 32'(v.exp_we));
          if (v.exp_we) chk("dmem_wdata", dmem_wdata, v.exp_wdata);
          if (acc == v.ack_cyc) begin
            dmem_ack = 1'b1;
            dmem_rdata = v.rdata;
          end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        chk("wb_bubble_rw", 32'(mem_wb_ctrl_reg_write), 32'd0);
        chk("wb_bubble_data", mem_wb_data, 32'd0);
      end else begin
        chk("dmem_req_retire", 32'(dmem_req), 32'd0);
        chk("pc_src", 32'(pc_src), 32'(v.exp_pcsrc));
        chk("pc_target", pc_target, v.exp_target);
        @(posedge clk); #1;
        chk("wb_rw", 32'(mem_wb_ctrl_reg_write), 32'(v.exp_rw));
        chk("wb_rd", 32'(mem_wb_rd), 32'(v.in.rd));
        chk("wb_data", mem_wb_data, v.exp_data);
        retired = 1;
      end
    end
    if (!retired) chk("retire_timeout", 32'd1, 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(v.exp_stalls));
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int   kind;
    kind = $urandom_range(0, 2);
    v.in.alu = $urandom;  v.in.b = $urandom;  v.in.pcb = $urandom;  v.in.pcj = $urandom;
    v.in.rd = 5'($urandom_range(0, 31));  v.in.rw = 1'($urandom_range(0, 1));
    v.in.m2r = (kind == 1);  v.in.mw = (kind == 2);
    v.in.lt = 3'($urandom_range(0, 4));  v.in.st = 2'($urandom_range(0, 2));
    v.in.br = 1'($urandom_range(0, 1));
    v.in.j = ($urandom_range(0, 3) == 0);  v.in.jr = ($urandom_range(0, 3) == 0);
    v.in.bt = 3'($urandom_range(0, 7));  v.in.flags = 6'($urandom_range(0, 63));
`ifdef MEM_MISALIGN_TRAP_EN
    if ((v.in.mw && v.in.st == 2'd0) || (v.in.m2r && v.in.lt == 3'd0)) v.in.alu = v.in.alu & ~32'h3;
    if ((v.in.mw && v.in.st == 2'd1) || (v.in.m2r && (v.in.lt == 3'd1 || v.in.lt == 3'd2)))
      v.in.alu = v.in.alu & ~32'h1;
`endif
    v.ack_cyc = $urandom_range(1, 4);
    v.rdata = $urandom;
    return model(v);
  endfunction

  vec_t   tbl[12];
  instr_t i;
  vec_t   rv;

  initial begin
    rst_n = 1'b0;  dmem_ack = 1'b0;  dmem_rdata = 32'd0;
    drive(nop());

    // Table vectors with hand-derived expectations
    i = nop(); i.alu = 32'h100; i.rd = 5'd8; i.rw = 1; i.m2r = 1; i.lt = 3'd0;
    tbl[0] = mkv(i, 1, 32'hDEADBEEF, 2, 32'h100, 4'hF, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    i.alu = 32'h103; i.lt = 3'd3;
    tbl[1] = mkv(i, 1, 32'h80112233, 2, 32'h100, 4'hF, 0, 0, 1, 32'hFFFFFF80, 0, 0);
    i.lt = 3'd4;
    tbl[2] = mkv(i, 2, 32'h80112233, 3, 32'h100, 4'hF, 0, 0, 1, 32'h00000080, 0, 0);
    i = nop(); i.alu = 32'h202; i.b = 32'h0000ABCD; i.mw = 1; i.st = 2'd1; i.rd = 5'd4;
    tbl[3] = mkv(i, 3, 32'h0, 4, 32'h200, 4'hC, 1, 32'hABCDABCD, 0, 32'h202, 0, 0);
    i = nop(); i.alu = 32'h55; i.rw = 1; i.rd = 5'd3; i.br = 1; i.bt = 3'd1; i.flags = 6'b000010;
    i.pcb = 32'h400; i.pcj = 32'h800;
    tbl[4] = mkv(i, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55, 1, 32'h400);
    i.flags = 6'b111101;
    tbl[5] = mkv(i, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 32'h400);
    i.bt = 3'd0; i.flags = 6'b000001; i.j = 1;
    tbl[6] = mkv(i, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55, 1, 32'h800);
    i.j = 0; i.bt = 3'd5; i.flags = 6'b100000;
    tbl[7] = mkv(i, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55, 1, 32'h400);
    i.bt = 3'd6; i.flags = 6'b111111;
    tbl[8] = mkv(i, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 32'h400);
    i = nop(); i.alu = 32'h1006; i.rw = 1; i.rd = 5'd12; i.m2r = 1; i.lt = 3'd1;
    tbl[9] = mkv(i, 1, 32'h80017FFF, 2, 32'h1004, 4'hF, 0, 0, 1, 32'hFFFF8001, 0, 0);
    i.alu = 32'h1004; i.lt = 3'd2;
    tbl[10] = mkv(i, 4, 32'h80019234, 5, 32'h1004, 4'hF, 0, 0, 1, 32'h00009234, 0, 0);
    i = nop(); i.alu = 32'h301; i.b = 32'h12345678; i.mw = 1; i.st = 2'd2; i.rw = 1; i.rd = 5'd7;
    tbl[11] = mkv(i, 2, 0, 3, 32'h300, 4'b0010, 1, 32'h78787878, 1, 32'h301, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_rw", 32'(mem_wb_ctrl_reg_write), 32'd0);
    chk("rst_wb_rd", 32'(mem_wb_rd), 32'd0);
    chk("rst_wb_data", mem_wb_data, 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) exec(tbl[k]);

    // Reset during ACCESS, then a late ack
    i = nop(); i.alu = 32'h600; i.m2r = 1; i.rw = 1; i.rd = 5'd9;
    drive(i);
    @(negedge clk);
    chk("rstacc_stall_idle", 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    chk("rstacc_req_access", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    drive(nop());
    #1;
    chk("rstacc_req_async", 32'(dmem_req), 32'd0);
    chk("rstacc_stall", 32'(stall_mem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1;  dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("lateack_stall", 32'(stall_mem), 32'd0);
    chk("lateack_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("lateack_wb_rw", 32'(mem_wb_ctrl_reg_write), 32'd0);
    chk("lateack_req_after", 32'(dmem_req), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    i = nop(); i.alu = 32'h101; i.m2r = 1; i.rw = 1; i.rd = 5'd2;
    drive(i);
    @(negedge clk);
    chk("mis_stall", 32'(stall_mem), 32'd0);
    chk("mis_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse", 32'(mem_misalign), 32'd1);
    chk("mis_wb_rw", 32'(mem_wb_ctrl_reg_write), 32'd0);
    chk("mis_req_after", 32'(dmem_req), 32'd0);
    drive(nop());
    @(posedge clk); #1;
    chk("mis_pulse_end", 32'(mem_misalign), 32'd0);
`endif

    // Randomized instructions against the reference model
    for (int k = 0; k < 200; k++) begin
      rv = rand_vec();
      exec(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM pipeline register outputs.
- Resolves branches and jumps, and performs load/store through a req/ack data-memory port with a multi-cycle access FSM.
- Aligns and extends load data and drives the MEM/WB register (mem_wb_data, mem_wb_rd, mem_wb_ctrl_reg_write) that feeds EX forwarding and writeback.

Parameters:
- ADDR_W, 32, data-memory byte address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ex_mem_alu_out  input  32  ALU result / memory byte address
- ex_mem_reg_b_data  input  32  store data
- ex_mem_rd  input  5  destination register
- ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write  input  1 each  control
- ex_mem_ctrl_load_type  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU
- ex_mem_ctrl_store_type  input  2  0 SW, 1 SH, 2 SB
- ex_mem_ctrl_branch, ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg  input  1 each  control
- ex_mem_ctrl_branch_type  input  3  0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ
- ex_mem_alu_{beq,bne,bgez,bgtz,blez,bltz}_sig  input  1 each  ALU condition flags
- ex_mem_pc_branch, ex_mem_pc_jump  input  32  targets
- dmem_req  output  1  access request (registered)
- dmem_we  output  1  write enable
- dmem_addr  output  ADDR_W  word-aligned address ({alu_out[31:2],2'b00})
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_ack  input  1  access complete; rdata valid same cycle
- dmem_rdata  input  32  read word
- pc_src  output  1  redirect fetch
- pc_target  output  32  redirect address
- stall_mem  output  1  freeze IF/ID/EX and the EX/MEM register
- mem_wb_data  output  32  writeback data
- mem_wb_rd  output  5  writeback register
- mem_wb_ctrl_reg_write  output  1  writeback enable

Behaviour:
- mem_op = ex_mem_ctrl_mem_to_reg | ex_mem_ctrl_mem_write.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if mem_op, go to ACCESS and set dmem_req=1 registered; dmem_we/addr/be/wdata are registered at the same edge and held stable through ACCESS.
  - ACCESS: on dmem_ack, capture dmem_rdata into a load buffer, drop dmem_req, go to DONE; otherwise remain.
  - DONE: unconditionally go to IDLE.
- stall_mem = (IDLE & mem_op) | ACCESS; combinational.
- Minimum memory-op cost: 2 stall cycles (ack in first ACCESS cycle). Non-memory ops never stall.
- MEM/WB register updates every edge:
  - stall_mem=1: bubble (reg_write=0, rd=0, data=0).
  - Otherwise: reg_write/rd copy ex_mem inputs; data = extended load buffer if mem_to_reg, else ex_mem_alu_out.
  - The instruction retires exactly once, in IDLE (non-mem) or DONE (mem).
- Load extension uses byte offset alu_out[1:0]:
  - LW: whole word.
  - LH/LHU: half at offset[1]; sign/zero extend.
  - LB/LBU: byte at offset; sign/zero extend.
  - Little-endian, byte 0 = bits 7:0.
- Store:
  - SW: be=1111.
  - SH: be=0011 or 1100 per offset[1]; wdata={2{b[15:0]}}.
  - SB: be=0001<<offset; wdata={4{b[7:0]}}.
  - Loads: be=1111.
- Branch: taken = ex_mem_ctrl_branch & flag selected by branch_type; types 6 and 7 are never taken.
- pc_src = (taken | jump | jump_reg) & ~stall_mem.
- pc_target = (jump|jump_reg) ? ex_mem_pc_jump : ex_mem_pc_branch. Jump wins if both are asserted.
- Reset values: state IDLE; dmem_req/we=0, dmem_addr/wdata=0, dmem_be=0; load buffer=0; all mem_wb_* =0. pc_src and stall_mem follow the input equations.
- Reset mid-ACCESS: dmem_req drops immediately (asynchronously); any late ack in IDLE is ignored.
- dmem_ack outside ACCESS is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is LW/SW with offset≠0, or LH/LHU/SH with offset[0]=1.
  - The access is suppressed: no request, FSM stays IDLE, no stall.
  - The instruction retires as a bubble.
  - Output mem_misalign (1-bit, registered) pulses one cycle; reset 0.
- Undefined:
  - No port and no check; the address is word-aligned and accessed as specified.

Test Plan:
- LW, alu_out=0x100, ack one cycle after req, rdata=0xDEADBEEF -> stall_mem high 2 cycles; dmem_addr=0x100, be=1111; then mem_wb_data=0xDEADBEEF, reg_write=1 for exactly one cycle.
- LB offset 3 and LBU offset 3, rdata=0x80112233 -> mem_wb_data=0xFFFFFF80, then 0x00000080.
- SH alu_out=0x202, b=0x0000ABCD, ack after 3 wait cycles -> be=1100, wdata=0xABCDABCD held stable; stall 4 cycles; reg_write=0.
- BNE branch_type=1, bne_sig=1, pc_branch=0x400 -> pc_src=1, pc_target=0x400; with bne_sig=0 -> pc_src=0.
- Reset asserted during ACCESS, then ack after release -> dmem_req=0 immediately; FSM IDLE; no writeback occurs.
- With MEM_MISALIGN_TRAP_EN: LW alu_out=0x101 -> no dmem_req; mem_misalign pulses one cycle; mem_wb_ctrl_reg_write=0.
